ex_issue_ctrl: RTL and testbench

- Issue/sequencing controller for the execute stage: accepts one decoded op per handshake from ID and drives the held alu_mode/rdn into the ALU.
- Holds multi-cycle multiply/divide ops for a fixed latency and presents a valid/ready result handshake to MEM.
- Back-pressures ID with a stall and aborts in-flight work on a pipeline flush (taken branch).

---
 rtl/ex_issue_ctrl.sv | 104 ++++++++++
 tb/tb_ex_issue_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue controller: holds one op, sequences mul/div latency, result handshake to MEM.
// Optional stall performance counter enabled by defining EX_PERF_CNT_EN.
module ex_issue_ctrl #(
  parameter int MulLatency = 3,
  parameter int DivLatency = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [7:0]  alu_mode_in,
  input  logic [4:0]  rdn_in,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [7:0]  alu_mode,
  output logic [4:0]  rdn,
  output logic        busy,
  output logic        stall,
  output logic        pend_valid,
  output logic [4:0]  pend_rdn,
  output logic [31:0] stall_cycles
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  // Counter runs latency-1 EXEC cycles: load latency-2, leave when it reads zero.
  localparam logic [3:0] MulLoad = 4'(MulLatency - 2);
  localparam logic [3:0] DivLoad = 4'(DivLatency - 2);

  state_t     state;
  logic [3:0] cnt;
  logic       accept;

  assign id_ready = ~flush & ((state == IDLE) | ((state == DONE) & ex_ready));
  assign accept   = id_valid & id_ready;
  assign stall    = id_valid & ~id_ready;
  assign pend_rdn = rdn;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_mode   <= '0;
      rdn        <= '0;
      ex_valid   <= 1'b0;
      busy       <= 1'b0;
      pend_valid <= 1'b0;
    end else if (flush) begin
      // Flush drops any held result; alu_mode/rdn intentionally keep their values.
      state      <= IDLE;
      cnt        <= '0;
      ex_valid   <= 1'b0;
      busy       <= 1'b0;
      pend_valid <= 1'b0;
    end else if (accept) begin
      alu_mode   <= alu_mode_in;
      rdn        <= rdn_in;
      pend_valid <= 1'b1;
      if (!alu_mode_in[7]) begin
        state    <= DONE;
        cnt      <= '0;
        ex_valid <= 1'b1;
        busy     <= 1'b0;
      end else begin
        state    <= EXEC;
        cnt      <= alu_mode_in[6] ? DivLoad : MulLoad;
        ex_valid <= 1'b0;
        busy     <= 1'b1;
      end
    end else begin
      case (state)
        EXEC: begin
          if (cnt == 4'd0) begin
            state    <= DONE;
            ex_valid <= 1'b1;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (ex_ready) begin
            state      <= IDLE;
            ex_valid   <= 1'b0;
            pend_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cycles <= '0;
    else if (stall & ~flush)
      stall_cycles <= stall_cycles + 32'd1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed bench for ex_issue_ctrl: occupancy/remaining-cycles model checked every cycle plus literal pins.
module tb_ex_issue_ctrl;
  localparam int MUL = 3;
  localparam int DIV = 8;
`ifdef EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        id_valid = 1'b0, flush = 1'b0, ex_ready = 1'b0;
  logic [7:0]  alu_mode_in = '0;
  logic [4:0]  rdn_in = '0;
  logic        id_ready, ex_valid, busy, stall, pend_valid;
  logic [7:0]  alu_mode;
  logic [4:0]  rdn, pend_rdn;
  logic [31:0] stall_cycles;

  ex_issue_ctrl #(.MulLatency(MUL), .DivLatency(DIV)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_ready(id_ready),
    .alu_mode_in(alu_mode_in), .rdn_in(rdn_in), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .alu_mode(alu_mode), .rdn(rdn), .busy(busy), .stall(stall),
    .pend_valid(pend_valid), .pend_rdn(pend_rdn), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int vec = 0, err = 0;
  bit chk_en = 1'b0;

  // Model: an op is either absent or present with some number of cycles left before its result shows.
  bit          occ = 1'b0;
  int          left = 0;
  logic [7:0]  m_mode = '0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_sc = '0;

  function automatic int lat(input logic [7:0] m);
    if (m[7:6] == 2'b10) return MUL;
    if (m[7:6] == 2'b11) return DIV;
    return 1;
  endfunction

  function automatic bit m_ev();
    return occ && left == 0;
  endfunction

  function automatic bit m_rdy();
    return !flush && (!occ || (m_ev() && ex_ready));
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ <= 1'b0; left <= 0; m_mode <= '0; m_rd <= '0; m_sc <= '0;
    end else begin
      automatic bit acc = id_valid && m_rdy();
      if (PERF && id_valid && !m_rdy() && !flush) m_sc <= m_sc + 32'd1;
      if (flush) begin
        occ <= 1'b0; left <= 0;
      end else if (acc) begin
        occ <= 1'b1; left <= lat(alu_mode_in) - 1;
        m_mode <= alu_mode_in; m_rd <= rdn_in;
      end else if (occ && left > 0) begin
        left <= left - 1;
      end else if (m_ev() && ex_ready) begin
        occ <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("id_ready",     32'(id_ready),   32'(m_rdy()));
      chk("stall",        32'(stall),      32'(id_valid && !m_rdy()));
      chk("ex_valid",     32'(ex_valid),   32'(m_ev()));
      chk("busy",         32'(busy),       32'(occ && left > 0));
      chk("pend_valid",   32'(pend_valid), 32'(occ));
      chk("pend_rdn",     32'(pend_rdn),   32'(m_rd));
      chk("alu_mode",     32'(alu_mode),   32'(m_mode));
      chk("rdn",          32'(rdn),        32'(m_rd));
      chk("stall_cycles", stall_cycles,    m_sc);
    end
  end

  task automatic cyc(input logic v, input logic [7:0] m, input logic [4:0] r,
                     input logic fl, input logic er);
    @(posedge clk); #1;
    id_valid = v; alu_mode_in = m; rdn_in = r; flush = fl; ex_ready = er;
    @(negedge clk);
  endtask

  logic [31:0] base;

  initial begin
    #2 rstn = 1'b0;
    chk_en = 1'b1;
    #20;
    @(negedge clk);
    chk("rst_ex_valid", 32'(ex_valid), 32'h0);
    chk("rst_alu_mode", 32'(alu_mode), 32'h0);
    chk("rst_sc", stall_cycles, 32'h0);
    rstn = 1'b1;

    // Single-cycle op
    cyc(1, 8'h05, 5'd7, 0, 1);
    chk("t1_ready", 32'(id_ready), 32'h1);
    cyc(0, 8'h00, 5'd0, 0, 1);
    chk("t1_ex_valid", 32'(ex_valid), 32'h1);
    chk("t1_alu_mode", 32'(alu_mode), 32'h05);
    chk("t1_rdn", 32'(rdn), 32'd7);
    chk("t1_ready2", 32'(id_ready), 32'h1);

    // Back-to-back single-cycle stream
    for (int i = 0; i < 4; i++) begin
      cyc(1, 8'(8'h10 + i), 5'(i + 1), 0, 1);
      chk("t2_stall", 32'(stall), 32'h0);
    end
    cyc(0, 8'h00, 5'd0, 0, 1);
    chk("t2_last", 32'(alu_mode), 32'h13);
    cyc(0, 8'h00, 5'd0, 0, 1);

    // Multiply: two busy cycles, result third cycle after accept, queued op accepted on result
    cyc(1, 8'h80, 5'd3, 0, 1);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 8'h01, 5'd4, 0, 1);
      chk("t3_busy", 32'(busy), 32'h1);
      chk("t3_ready", 32'(id_ready), 32'h0);
      chk("t3_stall", 32'(stall), 32'h1);
    end
    cyc(1, 8'h01, 5'd4, 0, 1);
    chk("t3_ex_valid", 32'(ex_valid), 32'h1);
    chk("t3_busy_off", 32'(busy), 32'h0);
    cyc(0, 8'h00, 5'd0, 0, 1);
    chk("t3_next", 32'(alu_mode), 32'h01);
    cyc(0, 8'h00, 5'd0, 0, 1);

    // Divide then flush four cycles later
    cyc(1, 8'hC0, 5'd9, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 5'd0, 0, 1);
    cyc(0, 8'h00, 5'd0, 1, 1);
    cyc(1, 8'h02, 5'd3, 0, 1);
    chk("t4_ex_valid", 32'(ex_valid), 32'h0);
    chk("t4_busy", 32'(busy), 32'h0);
    chk("t4_pend", 32'(pend_valid), 32'h0);
    chk("t4_keep_mode", 32'(alu_mode), 32'hC0);
    chk("t4_ready", 32'(id_ready), 32'h1);
    cyc(0, 8'h00, 5'd0, 0, 1);
    chk("t4_new_rdn", 32'(rdn), 32'd3);

    // Held result under back-pressure, five stalls then a flush
    cyc(1, 8'h20, 5'd11, 0, 0);
    base = m_sc;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'h21, 5'd12, 0, 0);
      chk("t5_hold_mode", 32'(alu_mode), 32'h20);
      chk("t5_hold_rdn", 32'(rdn), 32'd11);
      chk("t5_ready", 32'(id_ready), 32'h0);
    end
    cyc(1, 8'h21, 5'd12, 1, 0);
    cyc(0, 8'h00, 5'd0, 0, 0);
    chk("t5_perf", stall_cycles, base + (PERF ? 32'd5 : 32'd0));

    // Held result, then release with same-cycle accept, then release to idle
    cyc(1, 8'h30, 5'd13, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 5'd0, 0, 0);
    cyc(1, 8'h31, 5'd14, 0, 1);
    chk("t6_ready", 32'(id_ready), 32'h1);
    cyc(0, 8'h00, 5'd0, 0, 1);
    chk("t6_mode", 32'(alu_mode), 32'h31);
    chk("t6_valid", 32'(ex_valid), 32'h1);
    cyc(0, 8'h00, 5'd0, 0, 1);
    chk("t6_idle", 32'(pend_valid), 32'h0);

    // Flush coinciding with ex_ready in DONE: result dropped, no accept
    cyc(1, 8'h03, 5'd5, 0, 1);
    cyc(1, 8'h04, 5'd6, 1, 1);
    cyc(0, 8'h00, 5'd0, 0, 1);
    chk("t7_dropped", 32'(ex_valid), 32'h0);
    chk("t7_mode", 32'(alu_mode), 32'h03);

    // Asynchronous reset in the middle of a divide
    cyc(1, 8'hC5, 5'd17, 0, 1);
    cyc(0, 8'h00, 5'd0, 0, 1);
    cyc(0, 8'h00, 5'd0, 0, 1);
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("t8_busy", 32'(busy), 32'h0);
    chk("t8_mode", 32'(alu_mode), 32'h0);
    chk("t8_pend", 32'(pend_valid), 32'h0);
    rstn = 1'b1;
    for (int i = 0; i < DIV + 1; i++) begin
      cyc(0, 8'h00, 5'd0, 0, 1);
      chk("t8_no_done", 32'(ex_valid), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
